// File: rtl/srio_link_monitor_if.sv
// SRIO link monitor port bundle: raw status/control inputs and monitor results.
// Latency: none, wires only.
// Backpressure: none; level signals, the monitor samples every cycle.
interface srio_link_monitor_if #(
   parameter int DROP_CNT_W = 8
);
   // Raw status from the SRIO core (asynchronous to log_clk) and local control
   logic                  clk_lock_i;
   logic                  port_init_i;
   logic                  link_init_i;
   logic                  mode_1x_i;
   logic                  retrain_en_i;
   logic                  clr_stats_i;

   // Monitor results
   logic                  link_up_o;
   logic                  mode_1x_o;
   logic [2:0]            state_o;
   logic [DROP_CNT_W-1:0] link_drop_cnt_o;
   logic [31:0]           uptime_o;
   logic                  init_timeout_o;
   logic                  link_rst_req_o;

   // Environment side: drives status/control, observes results
   modport master (
      output clk_lock_i, port_init_i, link_init_i, mode_1x_i, retrain_en_i, clr_stats_i,
      input  link_up_o, mode_1x_o, state_o, link_drop_cnt_o, uptime_o,
             init_timeout_o, link_rst_req_o
   );

   // Monitor side
   modport slave (
      input  clk_lock_i, port_init_i, link_init_i, mode_1x_i, retrain_en_i, clr_stats_i,
      output link_up_o, mode_1x_o, state_o, link_drop_cnt_o, uptime_o,
             init_timeout_o, link_rst_req_o
   );
endinterface

// File: rtl/srio_link_monitor.sv
// SRIO link bring-up monitor: sync+debounce status, track state, count drops/uptime, issue core reset.
// Latency: raw status to debounced bit SYNC_STAGES+DEBOUNCE_CYCLES cycles, +1 to state, +1 more to link_up_o.
// Backpressure: none; all inputs are levels sampled every cycle.
module srio_link_monitor #(
   parameter int SYNC_STAGES      = 2,
   parameter int DEBOUNCE_CYCLES  = 16,
   parameter int INIT_TIMEOUT     = 1048576,
   parameter int RST_PULSE_CYCLES = 64,
   parameter int DROP_CNT_W       = 8
) (
   input logic                log_clk,
   input logic                sys_rst_n,
   srio_link_monitor_if.slave bus
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int TO_W = $clog2(INIT_TIMEOUT + 1);
   localparam int RP_W = $clog2(RST_PULSE_CYCLES + 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_PORT = 3'd1,
      WAIT_LINK = 3'd2,
      UP        = 3'd3,
      RESETTING = 3'd4,
      FAULT     = 3'd5
   } state_t;

   // Bit order: 0 clk_lock, 1 port_init, 2 link_init, 3 mode_1x
   logic [3:0]                   raw_i;
   logic [3:0][SYNC_STAGES-1:0]  sync_q;
   logic [3:0]                   sync_v;
   logic [2:0][DB_W-1:0]         db_cnt_q;
   logic [2:0]                   deb_q;

   state_t                       state_q, state_d;
   logic [TO_W-1:0]              tmo_cnt_q;
   logic [RP_W-1:0]              rp_cnt_q;
   logic [DROP_CNT_W-1:0]        drop_cnt_q;
   logic [31:0]                  uptime_q;
   logic                         tmo_flag_q;
   logic                         link_up_q;
   logic                         mode_q;
   logic                         rst_req_q;

   logic                         clk_ok, port_ok, link_ok;
   logic                         in_wait, tmo_hit, up_entry;
   logic                         drop_evt, tmo_evt;

   assign raw_i = {bus.mode_1x_i, bus.link_init_i, bus.port_init_i, bus.clk_lock_i};

   // Synchronizer chains, one per raw status bit
   always_ff @(posedge log_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sync_q <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw_i[i]};
         end
      end
   end

   // Pick the last stage of each chain
   always_comb begin
      sync_v = '0;
      for (int i = 0; i < 4; i++) begin
         sync_v[i] = sync_q[i][SYNC_STAGES-1];
      end
   end

   // Debounce: flip only after DEBOUNCE_CYCLES consecutive samples disagreeing with the held value
   always_ff @(posedge log_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         db_cnt_q <= '0;
         deb_q    <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (sync_v[i] == deb_q[i]) begin
               db_cnt_q[i] <= '0;
            end else if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
               deb_q[i]    <= sync_v[i];
               db_cnt_q[i] <= '0;
            end else begin
               db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
            end
         end
      end
   end

   assign clk_ok   = deb_q[0];
   assign port_ok  = deb_q[1];
   assign link_ok  = deb_q[2];
   assign in_wait  = (state_q == WAIT_PORT) || (state_q == WAIT_LINK);
   // >= keeps a counter parked at the limit re-firing after a WAIT_LINK -> WAIT_PORT fallback
   assign tmo_hit  = in_wait && (tmo_cnt_q >= TO_W'(INIT_TIMEOUT - 1));
   assign up_entry = (state_q != UP) && (state_d == UP);

   // Next state; priority is clk_lock loss, then port/link loss, then timeout, then progress
   always_comb begin
      state_d  = state_q;
      drop_evt = 1'b0;
      tmo_evt  = 1'b0;
      case (state_q)
         IDLE: begin
            if (clk_ok) state_d = WAIT_PORT;
         end
         WAIT_PORT: begin
            if (!clk_ok) begin
               state_d = IDLE;
            end else if (tmo_hit) begin
               tmo_evt = 1'b1;
               state_d = bus.retrain_en_i ? RESETTING : FAULT;
            end else if (port_ok) begin
               state_d = WAIT_LINK;
            end
         end
         WAIT_LINK: begin
            if (!clk_ok) begin
               state_d = IDLE;
            end else if (!port_ok) begin
               state_d = WAIT_PORT;
            end else if (tmo_hit) begin
               tmo_evt = 1'b1;
               state_d = bus.retrain_en_i ? RESETTING : FAULT;
            end else if (link_ok) begin
               state_d = UP;
            end
         end
         UP: begin
            if (!clk_ok) begin
               drop_evt = 1'b1;
               state_d  = IDLE;
            end else if (!port_ok || !link_ok) begin
               drop_evt = 1'b1;
               state_d  = bus.retrain_en_i ? RESETTING : WAIT_PORT;
            end
         end
         RESETTING: begin
            if (rp_cnt_q == RP_W'(RST_PULSE_CYCLES - 1)) state_d = IDLE;
         end
         FAULT: begin
            if (bus.clr_stats_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge log_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) state_q <= IDLE;
      else            state_q <= state_d;
   end

   // Init timeout counter: zero while IDLE/RESETTING, runs across both wait states
   always_ff @(posedge log_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         tmo_cnt_q <= '0;
      end else if ((state_q == IDLE) || (state_q == RESETTING)) begin
         tmo_cnt_q <= '0;
      end else if (in_wait && !tmo_hit) begin
         tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end
   end

   // Reset pulse length counter
   always_ff @(posedge log_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)                  rp_cnt_q <= '0;
      else if (state_q == RESETTING)   rp_cnt_q <= rp_cnt_q + 1'b1;
      else                             rp_cnt_q <= '0;
   end

   // Statistics: clear takes effect before a coincident drop is counted
   always_ff @(posedge log_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         drop_cnt_q <= '0;
         uptime_q   <= '0;
         tmo_flag_q <= 1'b0;
      end else begin
         if (bus.clr_stats_i)
            drop_cnt_q <= DROP_CNT_W'(drop_evt);
         else if (drop_evt && (drop_cnt_q != '1))
            drop_cnt_q <= drop_cnt_q + 1'b1;

         if (bus.clr_stats_i || up_entry)
            uptime_q <= '0;
         else if ((state_q == UP) && (uptime_q != '1))
            uptime_q <= uptime_q + 1'b1;

         tmo_flag_q <= (tmo_flag_q && !bus.clr_stats_i) || tmo_evt;
      end
   end

   // Registered status outputs
   always_ff @(posedge log_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         link_up_q <= 1'b0;
         mode_q    <= 1'b0;
         rst_req_q <= 1'b0;
      end else begin
         link_up_q <= (state_q == UP);
         rst_req_q <= (state_d == RESETTING);
         if (up_entry)            mode_q <= sync_v[3];
         else if (state_d != UP)  mode_q <= 1'b0;
      end
   end

   assign bus.link_up_o       = link_up_q;
   assign bus.mode_1x_o       = mode_q;
   assign bus.state_o         = state_q;
   assign bus.link_drop_cnt_o = drop_cnt_q;
   assign bus.uptime_o        = uptime_q;
   assign bus.init_timeout_o  = tmo_flag_q;
   assign bus.link_rst_req_o  = rst_req_q;

endmodule

// File: tb/tb_srio_link_monitor.sv
// Directed bench for srio_link_monitor: bring-up, glitch rejection, retrain, saturation, timeout, async reset.
// Latency: expected values are cycle-exact against negedge sampling.
// Backpressure: none.
module tb_srio_link_monitor;

   logic log_clk   = 1'b0;
   logic sys_rst_n = 1'b0;
   int   n_chk     = 0;
   int   n_pass    = 0;
   int   hi_cnt;

   srio_link_monitor_if #(.DROP_CNT_W(8)) bus ();

   srio_link_monitor #(
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (16),
      .INIT_TIMEOUT    (256),
      .RST_PULSE_CYCLES(64),
      .DROP_CNT_W      (8)
   ) dut (
      .log_clk  (log_clk),
      .sys_rst_n(sys_rst_n),
      .bus      (bus)
   );

   always #5 log_clk = ~log_clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // Bounded wait on negedges for a given state; expiry counts as a failed check
   task automatic wait_state(input string tag, input logic [2:0] exp, input int max_cyc);
      int n = 0;
      while ((bus.state_o !== exp) && (n < max_cyc)) begin
         @(negedge log_clk);
         n++;
      end
      if (bus.state_o !== exp) chk(tag, 32'(bus.state_o), 32'(exp));
   endtask

   initial begin
      bus.clk_lock_i   = 1'b0;
      bus.port_init_i  = 1'b0;
      bus.link_init_i  = 1'b0;
      bus.mode_1x_i    = 1'b1;
      bus.retrain_en_i = 1'b1;
      bus.clr_stats_i  = 1'b0;

      // Reset state
      repeat (3) @(negedge log_clk);
      chk("rst_state",   32'(bus.state_o), 0);
      chk("rst_link_up", 32'(bus.link_up_o), 0);
      chk("rst_req",     32'(bus.link_rst_req_o), 0);
      chk("rst_drop",    32'(bus.link_drop_cnt_o), 0);
      chk("rst_uptime",  bus.uptime_o, 0);
      chk("rst_timeout", 32'(bus.init_timeout_o), 0);
      chk("rst_mode",    32'(bus.mode_1x_o), 0);
      sys_rst_n = 1'b1;

      // Bring-up: clk_lock at N0, port_init at N100, link_init at N200
      @(negedge log_clk);
      bus.clk_lock_i = 1'b1;
      repeat (100) @(negedge log_clk);
      chk("bringup_wait_port", 32'(bus.state_o), 1);
      bus.port_init_i = 1'b1;
      repeat (100) @(negedge log_clk);
      chk("bringup_wait_link", 32'(bus.state_o), 2);
      bus.link_init_i = 1'b1;
      repeat (25) @(negedge log_clk);                      // N225, UP entered at E219
      chk("bringup_up",      32'(bus.state_o), 3);
      chk("bringup_link_up", 32'(bus.link_up_o), 1);
      chk("bringup_mode",    32'(bus.mode_1x_o), 1);
      chk("bringup_drop",    32'(bus.link_drop_cnt_o), 0);
      chk("uptime_a",        bus.uptime_o, 6);
      repeat (10) @(negedge log_clk);                      // N235
      chk("uptime_b",        bus.uptime_o, 16);

      // Short glitch on link_init is filtered
      bus.link_init_i = 1'b0;
      repeat (10) @(negedge log_clk);
      bus.link_init_i = 1'b1;
      repeat (20) @(negedge log_clk);                      // N265
      chk("glitch_state",  32'(bus.state_o), 3);
      chk("glitch_drop",   32'(bus.link_drop_cnt_o), 0);
      chk("glitch_uptime", bus.uptime_o, 46);

      // Real drop with retrain: detected at E284, 64-cycle reset pulse, back to IDLE at E348
      bus.link_init_i = 1'b0;
      repeat (19) @(negedge log_clk);                      // N284
      chk("drop_state",   32'(bus.state_o), 4);
      chk("drop_req",     32'(bus.link_rst_req_o), 1);
      chk("drop_cnt",     32'(bus.link_drop_cnt_o), 1);
      chk("drop_link_up_lag", 32'(bus.link_up_o), 1);
      hi_cnt = 0;
      for (int i = 0; i < 100; i++) begin
         if (i > 0) @(negedge log_clk);
         if (bus.link_rst_req_o) hi_cnt++;
         if (i == 1) chk("drop_link_up", 32'(bus.link_up_o), 0);
         if (i == 6) begin
            chk("uptime_held", bus.uptime_o, 65);
            chk("mode_cleared", 32'(bus.mode_1x_o), 0);
            bus.link_init_i = 1'b1;
         end
         if (i == 64) chk("idle_after_rst", 32'(bus.state_o), 0);
      end
      chk("rst_pulse_width", 32'(hi_cnt), 64);
      chk("reup_state", 32'(bus.state_o), 3);

      // Drive drops until the counter saturates
      for (int i = 0; i < 255; i++) begin
         bus.link_init_i = 1'b0;
         wait_state("sat_wait_rst", 3'd4, 40);
         bus.link_init_i = 1'b1;
         wait_state("sat_wait_up", 3'd3, 120);
         if (i == 253) chk("sat_at_255", 32'(bus.link_drop_cnt_o), 255);
      end
      chk("sat_hold", 32'(bus.link_drop_cnt_o), 255);

      // clr_stats on the very cycle the drop is registered
      bus.link_init_i = 1'b0;
      repeat (18) @(negedge log_clk);
      bus.clr_stats_i = 1'b1;
      @(negedge log_clk);
      bus.clr_stats_i = 1'b0;
      chk("clr_with_drop",       32'(bus.link_drop_cnt_o), 1);
      chk("clr_with_drop_state", 32'(bus.state_o), 4);

      // Timeout with retrain disabled: 256 cycles in WAIT_PORT then FAULT
      bus.retrain_en_i = 1'b0;
      bus.port_init_i  = 1'b0;
      wait_state("to_wait_port", 3'd1, 200);
      repeat (255) @(negedge log_clk);
      chk("to_before_state", 32'(bus.state_o), 1);
      chk("to_before_flag",  32'(bus.init_timeout_o), 0);
      @(negedge log_clk);
      chk("to_fault_state",  32'(bus.state_o), 5);
      chk("to_flag",         32'(bus.init_timeout_o), 1);
      repeat (20) @(negedge log_clk);
      chk("fault_hold",      32'(bus.state_o), 5);
      bus.clr_stats_i = 1'b1;
      @(negedge log_clk);
      bus.clr_stats_i = 1'b0;
      chk("fault_clr_state",  32'(bus.state_o), 0);
      chk("fault_clr_flag",   32'(bus.init_timeout_o), 0);
      chk("fault_clr_drop",   32'(bus.link_drop_cnt_o), 0);
      chk("fault_clr_uptime", bus.uptime_o, 0);

      // Async reset while RESETTING
      bus.retrain_en_i = 1'b1;
      bus.port_init_i  = 1'b1;
      bus.link_init_i  = 1'b1;
      wait_state("ar_wait_up", 3'd3, 300);
      bus.link_init_i = 1'b0;
      wait_state("ar_wait_rst", 3'd4, 40);
      chk("ar_req_before", 32'(bus.link_rst_req_o), 1);
      #2 sys_rst_n = 1'b0;
      #1;
      chk("ar_req",     32'(bus.link_rst_req_o), 0);
      chk("ar_state",   32'(bus.state_o), 0);
      chk("ar_drop",    32'(bus.link_drop_cnt_o), 0);
      chk("ar_link_up", 32'(bus.link_up_o), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
